// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection controller: lamp codes driven onto
// each approach and the phase encoding used by the phase scheduler.
package tlc_pkg;

   typedef logic [1:0] lamp_t;

   localparam lamp_t LAMP_RED    = 2'd0;
   localparam lamp_t LAMP_YELLOW = 2'd1;
   localparam lamp_t LAMP_GREEN  = 2'd2;

   typedef enum logic [1:0] {
      PH_GREEN   = 2'd0,
      PH_YELLOW  = 2'd1,
      PH_ALL_RED = 2'd2
   } phase_e;

   // Lamp code shown by the approach holding right-of-way in a given phase.
   function automatic lamp_t phase_lamp(input phase_e ph);
      lamp_t lamp;
      case (ph)
         PH_GREEN:  lamp = LAMP_GREEN;
         PH_YELLOW: lamp = LAMP_YELLOW;
         default:   lamp = LAMP_RED;
      endcase
      return lamp;
   endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Request/preempt inputs and lamp/phase outputs of the phase scheduler.
// master = traffic-side driver of requests, slave = the scheduler itself.
interface tlc_phase_scheduler_if #(
   parameter int N_APPR = 4
);
   import tlc_pkg::*;

   localparam int IDX_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

   logic [N_APPR-1:0]   req;
   logic                preempt;
   logic [IDX_W-1:0]    preempt_dir;
   logic [2*N_APPR-1:0] lights;
   logic [IDX_W-1:0]    active;
   phase_e              phase;

   modport master (
      output req, preempt, preempt_dir,
      input  lights, active, phase
   );

   modport slave (
      input  req, preempt, preempt_dir,
      output lights, active, phase
   );

endinterface

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec found by
// scanning upward from index start, wrapping at N.
module tlc_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_vec,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] pos_s;
   logic             hit_s;

   // Scan N positions starting at start; the first set bit wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      sum_s = '0;
      pos_s = '0;
      hit_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         sum_s = {1'b0, start} + (IDX_W+1)'(i);
         sum_s = (sum_s >= (IDX_W+1)'(N)) ? (sum_s - (IDX_W+1)'(N)) : sum_s;
         pos_s = sum_s[IDX_W-1:0];
         hit_s = !valid && req_vec[pos_s];
         idx   = hit_s ? pos_s : idx;
         valid = valid | req_vec[pos_s];
      end
   end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Top-level phase sequencer: latches approach requests, serves them
// round-robin through green -> yellow -> all-red -> new green, with an
// emergency preempt that redirects the next green but never shortens
// yellow or all-red clearance.
module tlc_phase_scheduler
   import tlc_pkg::*;
#(
   parameter int N_APPR    = 4,
   parameter int CNT_W     = 8,
   parameter int MIN_GREEN = 4,
   parameter int MAX_GREEN = 16,
   parameter int YELLOW    = 3,
   parameter int ALL_RED   = 2
) (
   input logic                  clock,
   input logic                  clear,
   tlc_phase_scheduler_if.slave bus
);

   localparam int IDX_W = (N_APPR > 1) ? $clog2(N_APPR) : 1;

   localparam logic [N_APPR-1:0]   ONE_N      = {{(N_APPR-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]    MIN_LAST   = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0]    MAX_LAST   = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0]    MAX_SAT    = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0]    Y_LAST     = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0]    AR_LAST    = CNT_W'(ALL_RED - 1);
   localparam logic [2*N_APPR-1:0] LIGHTS_RST = {{(2*N_APPR-2){1'b0}}, LAMP_GREEN};

   phase_e              phase_r,   phase_s;
   logic [IDX_W-1:0]    active_r,  active_s;
   logic [IDX_W-1:0]    target_r,  target_s;
   logic [CNT_W-1:0]    timer_r,   timer_s;
   logic [N_APPR-1:0]   pending_r, pending_s;
   logic [2*N_APPR-1:0] lights_r,  lights_s;

   logic [N_APPR-1:0]   onehot_active_s;
   logic [N_APPR-1:0]   req_masked_s;
   logic [N_APPR-1:0]   others_s;
   logic [IDX_W-1:0]    start_s;
   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_valid_s;
   logic                preempt_ok_s;
   logic                green_done_s;

   // Requests from other approaches, including this cycle's, and the search start.
   always_comb begin
      onehot_active_s = ONE_N << active_r;
      req_masked_s    = bus.req & ~onehot_active_s;
      others_s        = (pending_r & ~onehot_active_s) | req_masked_s;
      start_s         = (active_r == IDX_W'(N_APPR - 1)) ? '0 : (active_r + IDX_W'(1));
      preempt_ok_s    = bus.preempt && (int'(bus.preempt_dir) < N_APPR);
      green_done_s    = (timer_r >= MIN_LAST) &&
                        (!bus.req[active_r] || (timer_r >= MAX_LAST));
   end

   tlc_rr_pick #(
      .N     (N_APPR),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_vec (others_s),
      .start   (start_s),
      .idx     (pick_idx_s),
      .valid   (pick_valid_s)
   );

   // Next phase, right-of-way, target, request latch and phase timer.
   always_comb begin
      phase_s   = phase_r;
      active_s  = active_r;
      target_s  = target_r;
      pending_s = pending_r;
      timer_s   = timer_r;
      case (phase_r)
         PH_GREEN: begin
            pending_s = pending_r | req_masked_s;
            if (preempt_ok_s) begin
               if (bus.preempt_dir != active_r) begin
                  phase_s  = PH_YELLOW;
                  target_s = bus.preempt_dir;
               end else begin
                  phase_s  = PH_GREEN;
               end
            end else if (green_done_s && pick_valid_s) begin
               phase_s  = PH_YELLOW;
               target_s = pick_idx_s;
            end else begin
               phase_s  = PH_GREEN;
            end
         end
         PH_YELLOW: begin
            pending_s = pending_r | bus.req;
            target_s  = preempt_ok_s ? bus.preempt_dir : target_r;
            if (timer_r == Y_LAST) begin
               phase_s = PH_ALL_RED;
            end else begin
               phase_s = PH_YELLOW;
            end
         end
         PH_ALL_RED: begin
            pending_s = pending_r | bus.req;
            target_s  = preempt_ok_s ? bus.preempt_dir : target_r;
            if (timer_r == AR_LAST) begin
               // The new approach's request is consumed by its own green.
               phase_s   = PH_GREEN;
               active_s  = target_s;
               pending_s = (pending_r | bus.req) & ~(ONE_N << target_s);
            end else begin
               phase_s   = PH_ALL_RED;
            end
         end
         default: begin
            // Unknown phase code: fall back to full clearance.
            phase_s = PH_ALL_RED;
         end
      endcase

      if (phase_s != phase_r) begin
         timer_s = '0;
      end else if ((phase_r == PH_GREEN) && (timer_r >= MAX_SAT)) begin
         timer_s = MAX_SAT;
      end else begin
         timer_s = timer_r + CNT_W'(1);
      end
   end

   // Lamp codes for the next state, so lights change with the phase register.
   always_comb begin
      lights_s = '0;
      for (int i = 0; i < N_APPR; i++) begin
         lights_s[2*i +: 2] = (active_s == IDX_W'(i)) ? phase_lamp(phase_s) : LAMP_RED;
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         phase_r   <= PH_GREEN;
         active_r  <= '0;
         target_r  <= '0;
         timer_r   <= '0;
         pending_r <= '0;
         lights_r  <= LIGHTS_RST;
      end else begin
         phase_r   <= phase_s;
         active_r  <= active_s;
         target_r  <= target_s;
         timer_r   <= timer_s;
         pending_r <= pending_s;
         lights_r  <= lights_s;
      end
   end

   assign bus.lights = lights_r;
   assign bus.active = active_r;
   assign bus.phase  = phase_r;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler (4 approaches, MIN 4, MAX 16,
// yellow 3, all-red 2): a per-cycle vector table plus corner-case sequences.
module tb_tlc_phase_scheduler;

   logic clock = 1'b0;
   logic clear;

   always #5 clock = ~clock;

   tlc_phase_scheduler_if #(.N_APPR(4)) bus ();

   tlc_phase_scheduler #(
      .N_APPR    (4),
      .CNT_W     (8),
      .MIN_GREEN (4),
      .MAX_GREEN (16),
      .YELLOW    (3),
      .ALL_RED   (2)
   ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   typedef struct {
      logic       clr;
      logic [3:0] req;
      logic       pre;
      logic [1:0] dir;
      logic [7:0] lights;
      logic [1:0] active;
      logic [1:0] phase;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input int n, input logic clr, input logic [3:0] r,
                      input logic p, input logic [1:0] d,
                      input logic [7:0] l, input logic [1:0] a, input logic [1:0] ph);
      for (int k = 0; k < n; k++) begin
         vecs.push_back('{clr, r, p, d, l, a, ph});
      end
   endtask

   task automatic check(input string name, input logic [7:0] el,
                        input logic [1:0] ea, input logic [1:0] ep);
      n_checks++;
      if (bus.lights !== el || bus.active !== ea || bus.phase !== ep) begin
         n_fail++;
         $display("FAIL %s: got lights=%h active=%0d phase=%0d, expected lights=%h active=%0d phase=%0d",
                  name, bus.lights, bus.active, bus.phase, el, ea, ep);
      end
   endtask

   // Drive inputs away from the edge, take one clock edge, settle 1 time unit.
   task automatic step(input logic [3:0] r, input logic p, input logic [1:0] d);
      bus.req         = r;
      bus.preempt     = p;
      bus.preempt_dir = d;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear           = 1'b1;
      bus.req         = 4'b0000;
      bus.preempt     = 1'b0;
      bus.preempt_dir = 2'd0;
      #1;
      check("reset_async", 8'h02, 2'd0, 2'd0);
      @(posedge clock);
      #1;
      check("reset_hold", 8'h02, 2'd0, 2'd0);
      @(negedge clock);
      clear = 1'b0;
   endtask

   initial begin
      clear           = 1'b1;
      bus.req         = 4'b0000;
      bus.preempt     = 1'b0;
      bus.preempt_dir = 2'd0;

      // Single request from reset: 4 green, 3 yellow, 2 all-red, then approach 2.
      add(1, 1'b0, 4'b0100, 1'b0, 2'd0, 8'h02, 2'd0, 2'd0);
      add(2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h02, 2'd0, 2'd0);
      add(3, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h01, 2'd0, 2'd1);
      add(2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 2'd0, 2'd2);
      add(1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h20, 2'd2, 2'd0);
      // Round-robin from a fresh reset: req 1 and 3 together, 1 served then 3, 0 not revisited.
      add(1, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h02, 2'd0, 2'd0);
      add(1, 1'b0, 4'b1010, 1'b0, 2'd0, 8'h02, 2'd0, 2'd0);
      add(2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h02, 2'd0, 2'd0);
      add(3, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h01, 2'd0, 2'd1);
      add(2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 2'd0, 2'd2);
      add(4, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h08, 2'd1, 2'd0);
      add(3, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h04, 2'd1, 2'd1);
      add(2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00, 2'd1, 2'd2);
      add(6, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h80, 2'd3, 2'd0);

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         clear = vecs[i].clr;
         step(vecs[i].req, vecs[i].pre, vecs[i].dir);
         check($sformatf("vec%0d", i), vecs[i].lights, vecs[i].active, vecs[i].phase);
      end

      // Clear mid-yellow, then idle hold, then one-cycle request latency.
      do_reset();
      step(4'b0100, 1'b0, 2'd0);
      for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 2'd0);
      check("pre_clear_yellow", 8'h01, 2'd0, 2'd1);
      #2;
      clear = 1'b1;
      #1;
      check("clear_async", 8'h02, 2'd0, 2'd0);
      step(4'b0000, 1'b0, 2'd0);
      check("clear_held", 8'h02, 2'd0, 2'd0);
      clear = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(4'b0000, 1'b0, 2'd0);
         check("idle_hold", 8'h02, 2'd0, 2'd0);
      end
      step(4'b0010, 1'b0, 2'd0);
      check("req_latency_yellow", 8'h01, 2'd0, 2'd1);
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b0, 2'd0);
         check("req_latency_yellow_run", 8'h01, 2'd0, 2'd1);
      end
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b0, 2'd0);
         check("req_latency_allred", 8'h00, 2'd0, 2'd2);
      end
      step(4'b0000, 1'b0, 2'd0);
      check("req_latency_green", 8'h08, 2'd1, 2'd0);

      // Max green: req[0] held, req[1] pulsed; yellow exactly 16 cycles after green entry.
      do_reset();
      step(4'b0011, 1'b0, 2'd0);
      check("maxg_green", 8'h02, 2'd0, 2'd0);
      for (int i = 0; i < 14; i++) begin
         step(4'b0001, 1'b0, 2'd0);
         check("maxg_green_hold", 8'h02, 2'd0, 2'd0);
      end
      step(4'b0001, 1'b0, 2'd0);
      check("maxg_yellow", 8'h01, 2'd0, 2'd1);

      // Preempt to approach 3 at green cycle 1; req[1] waits until release.
      do_reset();
      step(4'b0000, 1'b0, 2'd0);
      check("pre_green_c1", 8'h02, 2'd0, 2'd0);
      step(4'b0000, 1'b1, 2'd3);
      check("pre_yellow_now", 8'h01, 2'd0, 2'd1);
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b1, 2'd3);
         check("pre_yellow_full", 8'h01, 2'd0, 2'd1);
      end
      for (int i = 0; i < 2; i++) begin
         step(4'b0000, 1'b1, 2'd3);
         check("pre_allred_full", 8'h00, 2'd0, 2'd2);
      end
      step(4'b0000, 1'b1, 2'd3);
      check("pre_green3", 8'h80, 2'd3, 2'd0);
      step(4'b0010, 1'b1, 2'd3);
      check("pre_hold_req1", 8'h80, 2'd3, 2'd0);
      for (int i = 0; i < 20; i++) begin
         step(4'b0000, 1'b1, 2'd3);
         check("pre_hold", 8'h80, 2'd3, 2'd0);
      end
      step(4'b0000, 1'b0, 2'd0);
      check("pre_release_serve", 8'h40, 2'd3, 2'd1);

      // Preempt on the active approach with req[2] pending: hold, then serve 2.
      do_reset();
      step(4'b0100, 1'b1, 2'd0);
      check("own_hold_first", 8'h02, 2'd0, 2'd0);
      for (int i = 0; i < 20; i++) begin
         step(4'b0000, 1'b1, 2'd0);
         check("own_hold", 8'h02, 2'd0, 2'd0);
      end
      step(4'b0000, 1'b0, 2'd0);
      check("own_release_yellow", 8'h01, 2'd0, 2'd1);
      for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 2'd0);
      check("own_yellow_end", 8'h01, 2'd0, 2'd1);
      for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 2'd0);
      check("own_allred_end", 8'h00, 2'd0, 2'd2);
      step(4'b0000, 1'b0, 2'd0);
      check("own_serve2", 8'h20, 2'd2, 2'd0);

      // req[target] on the green-entry edge is dropped.
      do_reset();
      step(4'b0010, 1'b0, 2'd0);
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 2'd0);
      check("drop_yellow", 8'h01, 2'd0, 2'd1);
      for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 2'd0);
      check("drop_allred", 8'h00, 2'd0, 2'd2);
      step(4'b0010, 1'b0, 2'd0);
      check("drop_green1", 8'h08, 2'd1, 2'd0);
      step(4'b1000, 1'b0, 2'd0);
      for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 2'd0);
      check("drop_green1_hold", 8'h08, 2'd1, 2'd0);
      step(4'b0000, 1'b0, 2'd0);
      check("drop_yellow1", 8'h04, 2'd1, 2'd1);
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 2'd0);
      check("drop_green3", 8'h80, 2'd3, 2'd0);
      for (int i = 0; i < 10; i++) begin
         step(4'b0000, 1'b0, 2'd0);
         check("drop_no_revisit", 8'h80, 2'd3, 2'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Multi-approach phase scheduler for the intersection controller. It latches vehicle requests from N approaches and picks the next approach round-robin. Each change runs through a fixed sequence: green, then yellow, then all-red, then the new approach's green, with programmable minimum/maximum green, yellow and all-red durations. An emergency preempt input overrides the normal order. The block is the top-level sequencer that drives the per-approach lamp codes.

## Interface
- N_APPR, 4: number of approaches (2..8)
- CNT_W, 8: phase timer width
- MIN_GREEN, 4: minimum green, cycles (≥1)
- MAX_GREEN, 16: maximum green while other approaches wait (≥MIN_GREEN)
- YELLOW, 3: yellow duration, cycles (≥1)
- ALL_RED, 2: all-red clearance, cycles (≥1)
- clock  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- req  in  N_APPR  per-approach vehicle request, level or 1-cycle pulse
- preempt  in  1  emergency preempt, level
- preempt_dir  in  $clog2(N_APPR)  approach to serve under preempt
- lights  out  2*N_APPR  lights[2i+1:2i] = approach i code (red=0, yellow=1, green=2)
- active  out  $clog2(N_APPR)  approach currently holding right-of-way
- phase  out  2  GREEN=0, YELLOW=1, ALL_RED=2

## Operation
- Reset values: phase=GREEN, active=0, timer=0, pending=0, target=0. lights shows approach 0 green and all others red.
- Request latching: `pending |= req & ~onehot(active)` every cycle while phase=GREEN.
  - In YELLOW and ALL_RED, every req bit is latched.
  - On entry to GREEN, pending[target] is cleared. A req for target in that same cycle is dropped.
- Phase timer: resets to 0 on every phase entry and increments each cycle. In GREEN it saturates at MAX_GREEN.
- GREEN exits to YELLOW when timer ≥ MIN_GREEN-1 and `others = pending & ~onehot(active)` is non-zero, and either of:
  - req[active]==0, or
  - timer ≥ MAX_GREEN-1.
- With no other request pending, GREEN dwells indefinitely.
- Target selection: captured on the GREEN→YELLOW edge as the first set bit of `others`, searching from active+1 upward with wrap.
- YELLOW exits to ALL_RED at timer==YELLOW-1.
- ALL_RED exits to GREEN at timer==ALL_RED-1, and active←target on that edge.
- Preempt with preempt_dir==active during GREEN: hold GREEN regardless of requests or MAX_GREEN.
- Preempt with preempt_dir≠active during GREEN: enter YELLOW on the next edge, ignoring MIN_GREEN, with target←preempt_dir.
- Preempt during YELLOW or ALL_RED: target←preempt_dir each cycle. The current phase still runs its full duration; yellow and all-red are never shortened.
- Preempt released: normal operation resumes. Pending requests are retained.
- Lamp mapping:
  - GREEN: active=green, others red.
  - YELLOW: active=yellow, others red.
  - ALL_RED: all red.
  - No two approaches are ever non-red simultaneously.

## Timing
- Moore outputs. lights, active and phase are registered and change on the same edge as the phase register.
- Phase durations, with no preempt:
  - GREEN ≥ MIN_GREEN cycles.
  - YELLOW = YELLOW cycles exactly.
  - ALL_RED = ALL_RED cycles exactly.
- Request to own green, idle intersection with timer already ≥ MIN_GREEN-1: yellow appears 1 cycle after req, and the target green appears YELLOW+ALL_RED cycles after yellow.
- clear asserted mid-phase: outputs take reset values immediately, asynchronously. The first transition is possible MIN_GREEN cycles after clear deasserts.

## Structure
- Shared package tlc_pkg holds the lamp codes (red/yellow/green) and the phase encoding (GREEN/YELLOW/ALL_RED). The existing controller's lamp constants move there as well.
- Sub-module tlc_rr_pick: combinational round-robin first-set-bit picker.
  - Inputs: request vector and start index.
  - Outputs: index and valid.

## Test plan
- Reset: assert clear mid-run, then release. Required: lights=8'h02, active=0, phase=0 immediately; the state holds for 100 cycles with no req.
- Single request: pulse req[2] 1 cycle right after reset. Required:
  - approach 0 green for 4 cycles, then yellow (lights=8'h01) for 3 cycles, then all-red (8'h00) for 2 cycles;
  - then lights=8'h20 and active=2.
- Round-robin: active=0, req[1] and req[3] pulsed together. Required: approach 1 served first, then 3, and 0 is not revisited without a new request.
- Max green: hold req[0] high and pulse req[1]. Required: yellow on approach 0 starts exactly 16 cycles after green entry.
- Preempt other: preempt=1, preempt_dir=3 at green cycle 1 of approach 0. Required: yellow on the next edge, full 3 yellow + 2 all-red, then lights=8'h80. A subsequent req[1] is not served while preempt is held.
- Preempt own and simultaneous events:
  - preempt_dir==active with req[2] pending: green held for the whole preempt, and approach 2 is served after release.
  - req[target] asserted on the GREEN-entry edge: the request is dropped.
